// File: rtl/store_run_tracker_if.sv
// Commit write port from store_run_tracker into the overflow range buffer.
// Each accepted transfer carries one closed store run [first, last].
interface store_run_tracker_if #(
    parameter int AW = 32
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_first;
    logic [AW-1:0] wr_last;

    modport master (
        output wr_valid,
        output wr_first,
        output wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_first,
        input  wr_last,
        output wr_ready
    );
endinterface

// File: rtl/store_run_tracker.sv
// Tracks runs of contiguous non-frame stores in EX, commits qualifying runs to the
// overflow range buffer, and pulses crash_o when a hit load is followed by a JALR.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE   | no run open; a tracked store opens one
// S_TRACK  | run open; contiguous stores extend it, date counts down on other ops
// S_COMMIT | run closed and qualifying; wr_valid held until the buffer accepts
module store_run_tracker #(
    parameter int AW            = 32,
    parameter int MIN_RUN_BYTES = 32,
    parameter int TIMEOUT       = 10,
    parameter int CNT_W         = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 en_crash_i,
    input  logic                 valid_i,
    input  logic                 op_store_i,
    input  logic                 op_load_i,
    input  logic                 op_jalr_i,
    input  logic [2:0]           store_size_i,
    input  logic                 base_is_frame_i,
    input  logic [AW-1:0]        addr_i,
    input  logic                 buf_hit_i,
    store_run_tracker_if.master  wr,
    output logic                 active_o,
    output logic                 crash_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [3:0]       DATE_INIT = 4'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_RUN_BYTES);

    state_t           state_q,     state_d;
    logic [AW-1:0]    start_q,     start_d;
    logic [AW-1:0]    end_q,       end_d;
    logic [2:0]       last_size_q, last_size_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [3:0]       date_q,      date_d;
    logic             load_hit_q,  load_hit_d;
    logic             crash_q,     crash_d;
    logic             wr_valid_q,  wr_valid_d;
    logic [AW-1:0]    wr_first_q,  wr_first_d;
    logic [AW-1:0]    wr_last_q,   wr_last_d;

    logic             size_ok;
    logic             is_store;
    logic             is_load;
    logic             is_jalr;
    logic             trk_store;
    logic [AW:0]      next_addr;
    logic             contig;
    logic [AW-1:0]    last_byte;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_sat;
    logic             qualifies;
    logic             in_run;
    logic             start_run;
    logic             close_run;

    // Illegal sizes demote the op to a non-store, so it falls through to load/jalr decode.
    assign size_ok   = (store_size_i == 3'd1) || (store_size_i == 3'd2) || (store_size_i == 3'd4);
    assign is_store  = valid_i & op_store_i & size_ok;
    assign is_load   = valid_i & ~is_store & op_load_i;
    assign is_jalr   = valid_i & ~is_store & ~op_load_i & op_jalr_i;
    assign trk_store = is_store & ~base_is_frame_i;

    // The carry bit keeps a run from wrapping past the top of the address space.
    assign next_addr = {1'b0, end_q} + (AW+1)'(last_size_q);
    assign contig    = ~next_addr[AW] && (next_addr[AW-1:0] == addr_i);
    assign last_byte = end_q + AW'(last_size_q) - AW'(1);

    assign cnt_sum   = {1'b0, count_q} + (CNT_W+1)'(store_size_i);
    assign cnt_sat   = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
    assign qualifies = (count_q > CNT_MIN);

    assign in_run    = (state_q == S_TRACK) && (addr_i >= start_q) && (addr_i <= last_byte);

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        end_d       = end_q;
        last_size_d = last_size_q;
        count_d     = count_q;
        date_d      = date_q;
        load_hit_d  = load_hit_q;
        crash_d     = 1'b0;
        wr_valid_d  = wr_valid_q;
        wr_first_d  = wr_first_q;
        wr_last_d   = wr_last_q;
        start_run   = 1'b0;
        close_run   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                start_run = trk_store;
            end
            S_TRACK: begin
                if (trk_store) begin
                    if (contig) begin
                        end_d       = addr_i;
                        last_size_d = store_size_i;
                        count_d     = cnt_sat;
                        date_d      = DATE_INIT;
                    end else if (qualifies) begin
                        close_run = 1'b1;
                    end else begin
                        start_run = 1'b1;
                    end
                end else if (valid_i) begin
                    if (date_q != 4'd0) begin
                        date_d = date_q - 4'd1;
                    end else begin
                        close_run = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                if (wr.wr_ready) begin
                    state_d    = S_IDLE;
                    wr_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_run) begin
            state_d     = S_TRACK;
            start_d     = addr_i;
            end_d       = addr_i;
            last_size_d = store_size_i;
            count_d     = CNT_W'(store_size_i);
            date_d      = DATE_INIT;
        end

        if (close_run) begin
            if (qualifies) begin
                state_d    = S_COMMIT;
                wr_valid_d = 1'b1;
                wr_first_d = start_q;
                wr_last_d  = last_byte;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (is_load) begin
            load_hit_d = buf_hit_i | in_run;
        end else if (is_jalr) begin
            crash_d    = en_crash_i & load_hit_q;
            load_hit_d = 1'b0;
        end

        if (clear_i) begin
            state_d     = S_IDLE;
            start_d     = '0;
            end_d       = '0;
            last_size_d = '0;
            count_d     = '0;
            date_d      = '0;
            load_hit_d  = 1'b0;
            crash_d     = 1'b0;
            wr_valid_d  = 1'b0;
            wr_first_d  = '0;
            wr_last_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            end_q       <= '0;
            last_size_q <= '0;
            count_q     <= '0;
            date_q      <= '0;
            load_hit_q  <= 1'b0;
            crash_q     <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_first_q  <= '0;
            wr_last_q   <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            end_q       <= end_d;
            last_size_q <= last_size_d;
            count_q     <= count_d;
            date_q      <= date_d;
            load_hit_q  <= load_hit_d;
            crash_q     <= crash_d;
            wr_valid_q  <= wr_valid_d;
            wr_first_q  <= wr_first_d;
            wr_last_q   <= wr_last_d;
        end
    end

    assign wr.wr_valid = wr_valid_q;
    assign wr.wr_first = wr_first_q;
    assign wr.wr_last  = wr_last_q;
    assign active_o    = (state_q == S_TRACK);
    assign crash_o     = crash_q;

endmodule

// File: tb/tb_store_run_tracker.sv
// Bench for store_run_tracker: directed scenarios plus a randomized run, all checked
// against a run-level reference model (byte spans, quiet-op counts, pending commit).
module tb_store_run_tracker;

    localparam int MIN_RUN = 32;
    localparam int TMO     = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        en_crash = 1'b0;
    logic        valid = 1'b0;
    logic        op_store = 1'b0;
    logic        op_load = 1'b0;
    logic        op_jalr = 1'b0;
    logic [2:0]  store_size = 3'd0;
    logic        frame = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        buf_hit = 1'b0;
    logic        active;
    logic        crash;

    store_run_tracker_if #(.AW(32)) wr_if ();

    store_run_tracker dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clear),
        .en_crash_i      (en_crash),
        .valid_i         (valid),
        .op_store_i      (op_store),
        .op_load_i       (op_load),
        .op_jalr_i       (op_jalr),
        .store_size_i    (store_size),
        .base_is_frame_i (frame),
        .addr_i          (addr),
        .buf_hit_i       (buf_hit),
        .wr              (wr_if),
        .active_o        (active),
        .crash_o         (crash)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 = no run, 1 = run open, 2 = waiting on commit handshake.
    int     m_mode;
    longint m_first, m_next;
    int     m_bytes, m_quiet;
    longint m_pf, m_pl;
    bit     m_hit, e_crash;

    task automatic model_reset();
        m_mode = 0; m_first = 0; m_next = 0; m_bytes = 0; m_quiet = 0;
        m_pf = 0; m_pl = 0; m_hit = 0; e_crash = 0;
    endtask

    task automatic model_begin(longint a, int sz);
        m_mode = 1; m_first = a; m_next = a + sz; m_bytes = sz; m_quiet = 0;
    endtask

    task automatic model_close();
        if (m_bytes > MIN_RUN) begin
            m_pf = m_first; m_pl = m_next - 1; m_mode = 2;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic model_step();
        int     mode0 = m_mode;
        longint a = longint'({32'd0, addr});
        int     sz = int'(store_size);
        bit     st, ld, jr, trk;
        if (clear) begin
            model_reset();
            return;
        end
        e_crash = 0;
        if (valid) begin
            st  = op_store && (sz == 1 || sz == 2 || sz == 4);
            ld  = !st && op_load;
            jr  = !st && !op_load && op_jalr;
            trk = st && !frame;
            if (ld) begin
                m_hit = buf_hit || (mode0 == 1 && a >= m_first && a < m_next);
            end else if (jr) begin
                e_crash = en_crash && m_hit;
                m_hit = 0;
            end
            if (mode0 == 0 && trk) begin
                model_begin(a, sz);
            end else if (mode0 == 1) begin
                if (trk) begin
                    if (a == m_next) begin
                        m_next = a + sz;
                        m_bytes = (m_bytes + sz > 65535) ? 65535 : m_bytes + sz;
                        m_quiet = 0;
                    end else if (m_bytes > MIN_RUN) begin
                        model_close();
                    end else begin
                        model_begin(a, sz);
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet > TMO) model_close();
                end
            end
        end
        if (mode0 == 2 && wr_if.wr_ready) m_mode = 0;
    endtask

    task automatic set_op(bit v, bit s, bit l, bit j, logic [2:0] sz, bit f, logic [31:0] a, bit h);
        valid = v; op_store = s; op_load = l; op_jalr = j;
        store_size = sz; frame = f; addr = a; buf_hit = h;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_op(1, 0, 0, 0, 3'd0, 0, 32'd0, 0);
        tick();
    endtask

    task automatic sw(logic [31:0] a);
        set_op(1, 1, 0, 0, 3'd4, 0, a, 0);
        tick();
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({wr_if.wr_valid, active, crash} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%b want=000", {wr_if.wr_valid, active, crash});
        end
        vectors++;
        if (wr_if.wr_first !== 32'd0 || wr_if.wr_last !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data got=%h/%h want=0/0", wr_if.wr_first, wr_if.wr_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_long_run();
        for (int i = 0; i < 9; i++) sw(32'h1000 + 32'(4 * i));
        vectors++;
        if (active !== 1'b1) begin
            miscompares++;
            $display("FAIL long_active got=%b want=1", active);
        end
        for (int i = 0; i < 10; i++) nop();
        vectors++;
        if ({wr_if.wr_valid, active} !== 2'b01) begin
            miscompares++;
            $display("FAIL long_10nop got=%b want=01", {wr_if.wr_valid, active});
        end
        nop();
        vectors++;
        if ({wr_if.wr_valid, active} !== 2'b10 || wr_if.wr_first !== 32'h1000 || wr_if.wr_last !== 32'h1023) begin
            miscompares++;
            $display("FAIL long_commit got=%b %h %h want=10 00001000 00001023",
                     {wr_if.wr_valid, active}, wr_if.wr_first, wr_if.wr_last);
        end
        wr_if.wr_ready = 1'b1;
        nop();
        wr_if.wr_ready = 1'b0;
        vectors++;
        if ({wr_if.wr_valid, active} !== 2'b00) begin
            miscompares++;
            $display("FAIL long_ack got=%b want=00", {wr_if.wr_valid, active});
        end
    endtask

    task automatic test_short_run();
        int seen = 0;
        for (int i = 0; i < 8; i++) sw(32'h1000 + 32'(4 * i));
        for (int i = 0; i < 13; i++) begin
            nop();
            if (wr_if.wr_valid !== 1'b0) seen++;
        end
        vectors++;
        if (seen != 0 || active !== 1'b0) begin
            miscompares++;
            $display("FAIL short_no_commit got valid_cycles=%0d active=%b want=0 0", seen, active);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 9; i++) sw(32'h2000 + 32'(4 * i));
        set_op(1, 1, 0, 0, 3'd1, 0, 32'h3000, 0);
        tick();
        vectors++;
        if ({wr_if.wr_valid, active} !== 2'b10 || wr_if.wr_first !== 32'h2000 || wr_if.wr_last !== 32'h2023) begin
            miscompares++;
            $display("FAIL bp_commit got=%b %h %h want=10 00002000 00002023",
                     {wr_if.wr_valid, active}, wr_if.wr_first, wr_if.wr_last);
        end
        for (int i = 0; i < 3; i++) begin
            sw(32'h2024 + 32'(4 * i));
            vectors++;
            if ({wr_if.wr_valid, active} !== 2'b10 || wr_if.wr_first !== 32'h2000 || wr_if.wr_last !== 32'h2023) begin
                miscompares++;
                $display("FAIL bp_hold%0d got=%b %h %h want=10 00002000 00002023",
                         i, {wr_if.wr_valid, active}, wr_if.wr_first, wr_if.wr_last);
            end
        end
        wr_if.wr_ready = 1'b1;
        nop();
        wr_if.wr_ready = 1'b0;
        vectors++;
        if ({wr_if.wr_valid, active} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_release got=%b want=00", {wr_if.wr_valid, active});
        end
    endtask

    task automatic test_frame();
        for (int i = 0; i < 9; i++) begin
            sw(32'h4000 + 32'(4 * i));
            if (i % 3 == 1) begin
                set_op(1, 1, 0, 0, 3'd4, 1, 32'h7FF0, 0);
                tick();
            end
        end
        set_op(1, 1, 0, 0, 3'd4, 1, 32'h7FF0, 0);
        tick();
        for (int i = 0; i < 9; i++) nop();
        vectors++;
        if ({wr_if.wr_valid, active} !== 2'b01) begin
            miscompares++;
            $display("FAIL frame_still_open got=%b want=01", {wr_if.wr_valid, active});
        end
        nop();
        vectors++;
        if (wr_if.wr_valid !== 1'b1 || wr_if.wr_first !== 32'h4000 || wr_if.wr_last !== 32'h4023) begin
            miscompares++;
            $display("FAIL frame_commit got=%b %h %h want=1 00004000 00004023",
                     wr_if.wr_valid, wr_if.wr_first, wr_if.wr_last);
        end
        wr_if.wr_ready = 1'b1;
        nop();
        wr_if.wr_ready = 1'b0;
    endtask

    task automatic test_crash();
        bit [2:0] got;
        for (int e = 1; e >= 0; e--) begin
            en_crash = 1'(e);
            set_op(1, 0, 1, 0, 3'd0, 0, 32'h2010, 1);
            tick();
            set_op(1, 0, 0, 1, 3'd0, 0, 32'h0, 0);
            tick();
            got[0] = crash;
            nop();
            got[1] = crash;
            set_op(1, 0, 0, 1, 3'd0, 0, 32'h0, 0);
            tick();
            nop();
            got[2] = crash;
            vectors++;
            if (got !== {2'b00, 1'(e)}) begin
                miscompares++;
                $display("FAIL crash_en%0d got=%b want=%b", e, got, {2'b00, 1'(e)});
            end
        end
        en_crash = 1'b0;
    endtask

    task automatic test_clear_commit();
        for (int i = 0; i < 9; i++) sw(32'h2000 + 32'(4 * i));
        set_op(1, 1, 0, 0, 3'd1, 0, 32'h3000, 0);
        tick();
        set_op(0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if ({wr_if.wr_valid, active} !== 2'b00) begin
            miscompares++;
            $display("FAIL clear_commit got=%b want=00", {wr_if.wr_valid, active});
        end
    endtask

    task automatic test_async_reset();
        sw(32'h5000);
        sw(32'h5004);
        vectors++;
        if (active !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre got=%b want=1", active);
        end
        set_op(0, 0, 0, 0, 3'd0, 0, 32'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if ({wr_if.wr_valid, active, crash} !== 3'b000) begin
            miscompares++;
            $display("FAIL areset_mid got=%b want=000", {wr_if.wr_valid, active, crash});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_wrap();
        sw(32'hFFFF_FFF8);
        sw(32'hFFFF_FFFC);
        for (int i = 0; i < 9; i++) sw(32'(4 * i));
        for (int i = 0; i < 11; i++) nop();
        vectors++;
        if (wr_if.wr_valid !== 1'b1 || wr_if.wr_first !== 32'h0 || wr_if.wr_last !== 32'h23) begin
            miscompares++;
            $display("FAIL wrap_commit got=%b %h %h want=1 00000000 00000023",
                     wr_if.wr_valid, wr_if.wr_first, wr_if.wr_last);
        end
        wr_if.wr_ready = 1'b1;
        nop();
        wr_if.wr_ready = 1'b0;
    endtask

    task automatic test_random();
        int r, sz, k;
        logic [31:0] a;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            clear = ($urandom_range(0, 299) == 0);
            en_crash = $urandom_range(0, 1);
            wr_if.wr_ready = ($urandom_range(0, 9) < 3);
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 99);
            sz = (k < 70) ? 4 : (k < 82) ? 2 : (k < 96) ? 1 : 3;
            if (m_mode == 1 && $urandom_range(0, 9) != 0) a = m_next[31:0];
            else if ($urandom_range(0, 49) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else a = 32'h1000 + 32'($urandom_range(0, 63) * 4);
            if (r < 8) begin
                set_op(0, $urandom_range(0, 1), 0, 0, 3'(sz), 0, a, 0);
            end else if (r < 68) begin
                set_op(1, 1, 0, 0, 3'(sz), ($urandom_range(0, 9) == 0), a, 0);
            end else if (r < 82) begin
                a = m_first[31:0] + 32'($urandom_range(0, 72)) - 32'd4;
                set_op(1, 0, 1, 0, 3'd0, 0, a, ($urandom_range(0, 3) == 0));
            end else if (r < 92) begin
                set_op(1, 0, 0, 1, 3'd0, 0, a, 0);
            end else begin
                set_op(1, 0, 0, 0, 3'd0, 0, a, 0);
            end
            tick();
            vectors++;
            if ({wr_if.wr_valid, active, crash} !== {m_mode == 2, m_mode == 1, e_crash}) begin
                miscompares++;
                $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", cyc,
                         {wr_if.wr_valid, active, crash}, {m_mode == 2, m_mode == 1, e_crash});
            end
            if (m_mode == 2) begin
                vectors++;
                if (wr_if.wr_first !== m_pf[31:0] || wr_if.wr_last !== m_pl[31:0]) begin
                    miscompares++;
                    $display("FAIL rand_range cyc=%0d got=%h/%h want=%h/%h", cyc,
                             wr_if.wr_first, wr_if.wr_last, m_pf[31:0], m_pl[31:0]);
                end
            end
        end
        clear = 1'b0;
        wr_if.wr_ready = 1'b0;
    endtask

    initial begin
        wr_if.wr_ready = 1'b0;
        model_reset();
        test_reset();
        test_long_run();
        test_short_run();
        test_backpressure();
        test_frame();
        test_crash();
        test_clear_commit();
        test_async_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
